mem_port_arbiter: RTL and testbench

- Arbitrates one single-ported data memory (memory2c-style) between the fetch stage (read-only) and the memory stage (read/write).
- Sequences each access over a fixed multi-cycle latency.
- Returns read data with a one-cycle done pulse and drives the stall requests for both stages.
- Issues the final memory dump on halt.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states, access owner,
// default bus widths and the latency-counter width helper.
package mem_port_arbiter_pkg;

  localparam int DEF_DW  = 16;
  localparam int DEF_AW  = 16;
  localparam int DEF_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requestor, memory and control signals of the arbiter; slave is the arbiter side,
// master is the side that drives the requests and models the memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          halt;
  logic          stall_if;
  logic          stall_mem;
  logic          ram_en;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_dump;
  logic          err;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, halt, ram_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
           ram_en, ram_wr, ram_addr, ram_wdata, ram_dump, err
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, halt, ram_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
           ram_en, ram_wr, ram_addr, ram_wdata, ram_dump, err
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter timing the memory latency; o_zero flags the capture cycle.
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  localparam int CW = cnt_width(LAT)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (read-only) and memory stage
// (read/write); data side wins ties, halt triggers a single dump and parks the FSM.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int LAT = DEF_LAT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int            CW     = cnt_width(LAT);
  localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);

  state_t        r_state;
  logic          r_owner;
  logic          r_wflag;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_ram_en;
  logic          r_if_done;
  logic          r_mem_done;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic          r_dump;
  logic          r_err;

  logic w_mem_req;
  logic w_load;
  logic w_dec;
  logic w_zero;

  assign w_mem_req = bus.mem_rd | bus.mem_wr;
  assign w_load    = (r_state == S_IDLE) & (w_mem_req | bus.if_req);
  assign w_dec     = ((r_state == S_ISSUE) | (r_state == S_WAIT)) & ~w_zero;

  // Loaded on the grant, so the count reads LAT-1 during ISSUE and hits zero
  // in the cycle whose closing edge samples ram_rdata.
  mem_lat_counter #(.LAT(LAT)) u_lat_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (LAT_M1),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_IF;
      r_wflag     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ram_en    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_dump      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ram_en   <= 1'b0;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_dump     <= 1'b0;
      if (bus.mem_rd & bus.mem_wr) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_mem_req) begin
            r_owner  <= OWN_MEM;
            r_wflag  <= bus.mem_wr;
            r_addr   <= bus.mem_addr;
            r_wdata  <= bus.mem_wdata;
            r_ram_en <= 1'b1;
            r_state  <= S_ISSUE;
          end else if (bus.if_req) begin
            r_owner  <= OWN_IF;
            r_wflag  <= 1'b0;
            r_addr   <= bus.if_addr;
            r_ram_en <= 1'b1;
            r_state  <= S_ISSUE;
          end else if (bus.halt) begin
            r_dump  <= 1'b1;
            r_state <= S_HALTED;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_zero) begin
            if (r_owner == OWN_MEM) begin
              if (!r_wflag) r_mem_rdata <= bus.ram_rdata;
              r_mem_done <= 1'b1;
            end else begin
              r_if_rdata <= bus.ram_rdata;
              r_if_done  <= 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_DONE:   r_state <= S_IDLE;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_wr    = r_ram_en & (r_owner == OWN_MEM) & r_wflag;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_dump  = r_dump;
  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.err       = r_err;
  assign bus.stall_if  = bus.if_req & ~r_if_done;
  assign bus.stall_mem = w_mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected accesses are queued at drive time
// and checked when ram_en and the done pulses appear; includes a latency-LAT memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_port_arbiter_if #(.DW(16), .AW(16)) bus();

  mem_port_arbiter #(.DW(16), .AW(16), .LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        own;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          exp_en;
  } txn_t;

  txn_t        sb[$];
  logic [15:0] tb_mem [0:255];
  int          n_en = 0, n_done = 0, n_dump = 0;
  int          en_cyc = 0, dump_cyc = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_data = '0;
  logic [15:0] exp_if_rd = '0, exp_mem_rd = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic own, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input int exp_en);
    txn_t t;
    t.own    = own;
    t.wr     = wr;
    t.addr   = addr;
    t.wdata  = wdata;
    t.rdata  = tb_mem[addr[7:0]];
    t.exp_en = exp_en;
    sb.push_back(t);
  endtask

  task automatic wait_done(input logic own, input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (own ? bus.mem_done : bus.if_done) return;
    end
    chk(tag, own ? bus.mem_done : bus.if_done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},   {bus.ram_en, bus.ram_wr, bus.ram_dump, bus.err, bus.if_done, bus.mem_done}, 0);
    chk({tag, "_addr"},  bus.ram_addr, 0);
    chk({tag, "_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_ifrd"},  bus.if_rdata, 0);
    chk({tag, "_memrd"}, bus.mem_rdata, 0);
  endtask

  // Called at a negedge; the zero check happens before any further clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory model and output monitor.
  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      pend_cnt      = 0;
      exp_if_rd     = '0;
      exp_mem_rd    = '0;
      bus.ram_rdata = 16'hDEAD;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        bus.ram_rdata = (pend_cnt == 0) ? pend_data : 16'hDEAD;
      end else begin
        bus.ram_rdata = 16'hDEAD;
      end
      if (bus.ram_en) begin
        n_en++;
        en_cyc = cyc;
        chk("en_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb[0];
          chk("en_wr", bus.ram_wr, e.wr);
          chk("en_addr", bus.ram_addr, e.addr);
          if (e.wr) chk("en_wdata", bus.ram_wdata, e.wdata);
          if (e.exp_en >= 0) chk("en_cyc", cyc, e.exp_en);
        end
        if (bus.ram_wr) begin
          tb_mem[bus.ram_addr[7:0]] = bus.ram_wdata;
        end else begin
          pend_data = tb_mem[bus.ram_addr[7:0]];
          pend_cnt  = LAT - 1;
        end
      end
      if (bus.if_done || bus.mem_done) begin
        n_done++;
        chk("done_both", {bus.if_done, bus.mem_done}, bus.mem_done ? 2'b01 : 2'b10);
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_owner", bus.mem_done, e.own);
          chk("done_lat", cyc, en_cyc + LAT);
          if (!e.wr) begin
            if (e.own == OWN_MEM) exp_mem_rd = e.rdata;
            else                  exp_if_rd  = e.rdata;
          end
          chk("if_rdata", bus.if_rdata, exp_if_rd);
          chk("mem_rdata", bus.mem_rdata, exp_mem_rd);
        end
      end
      if (bus.ram_dump) begin
        n_dump++;
        dump_cyc = cyc;
      end
    end
  end

  initial begin
    int t, tdone, e0, d0, dump0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'hA000 + 16'(i);
    tb_mem[8'h10] = 16'h1234;
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.mem_rd = 1'b0;  bus.mem_wr = 1'b0;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    bus.halt = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_stall", {bus.stall_if, bus.stall_mem}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single fetch read
    t = cyc;
    bus.if_addr = 16'h0010;
    bus.if_req  = 1'b1;
    push(OWN_IF, 1'b0, 16'h0010, 16'h0, t + 1);
    #1 chk("t1_stall_t0", bus.stall_if, 1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("t1_stall", bus.stall_if, 1);
      chk("t1_no_done", bus.if_done, 0);
    end
    @(negedge clk);
    chk("t1_done", bus.if_done, 1);
    chk("t1_done_cyc", cyc, t + 3);
    chk("t1_stall_end", bus.stall_if, 0);
    chk("t1_rdata", bus.if_rdata, 16'h1234);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("t1_pulse", bus.if_done, 0);
    chk("t1_hold", bus.if_rdata, 16'h1234);

    // 2: simultaneous fetch and write, data side first
    repeat (2) @(negedge clk);
    t = cyc;
    bus.if_addr = 16'h0020;  bus.if_req = 1'b1;
    bus.mem_addr = 16'h0040; bus.mem_wdata = 16'hBEEF; bus.mem_wr = 1'b1;
    push(OWN_MEM, 1'b1, 16'h0040, 16'hBEEF, t + 1);
    push(OWN_IF, 1'b0, 16'h0020, 16'h0, t + 5);
    #1 chk("t2_stall_mem", bus.stall_mem, 1);
    wait_done(OWN_MEM, "t2_mem_timeout");
    chk("t2_mem_cyc", cyc, t + 3);
    chk("t2_if_stalled", bus.stall_if, 1);
    bus.mem_wr = 1'b0;
    wait_done(OWN_IF, "t2_if_timeout");
    chk("t2_if_cyc", cyc, t + 7);
    bus.if_req = 1'b0;

    // 3: back-to-back reads with mem_rd held
    repeat (2) @(negedge clk);
    t = cyc;
    bus.mem_addr = 16'h0002; bus.mem_rd = 1'b1;
    push(OWN_MEM, 1'b0, 16'h0002, 16'h0, t + 1);
    wait_done(OWN_MEM, "t3_a_timeout");
    chk("t3_a_cyc", cyc, t + 3);
    bus.mem_addr = 16'h0004;
    push(OWN_MEM, 1'b0, 16'h0004, 16'h0, t + 5);
    wait_done(OWN_MEM, "t3_b_timeout");
    chk("t3_b_cyc", cyc, t + 7);
    bus.mem_rd = 1'b0;
    @(negedge clk);
    chk("t3_hold", bus.mem_rdata, 16'hA004);

    // 4: halt raised mid-access
    repeat (2) @(negedge clk);
    dump0 = n_dump;
    t = cyc;
    bus.mem_addr = 16'h0006; bus.mem_rd = 1'b1;
    push(OWN_MEM, 1'b0, 16'h0006, 16'h0, t + 1);
    repeat (2) @(negedge clk);
    bus.halt = 1'b1;
    wait_done(OWN_MEM, "t4_timeout");
    chk("t4_done_cyc", cyc, t + 3);
    bus.mem_rd = 1'b0;
    tdone = cyc;
    repeat (4) @(negedge clk);
    chk("t4_dump_n", n_dump - dump0, 1);
    chk("t4_dump_cyc", dump_cyc, tdone + 2);
    e0 = n_en;
    bus.if_addr = 16'h0010; bus.if_req = 1'b1;
    repeat (8) @(negedge clk);
    chk("t4_no_grant", n_en, e0);
    chk("t4_stall_halt", bus.stall_if, 1);
    chk("t4_dump_once", n_dump - dump0, 1);
    bus.if_req = 1'b0; bus.halt = 1'b0;
    @(negedge clk);
    do_reset("t4_rst");

    // 5: reset during WAIT
    repeat (2) @(negedge clk);
    bus.if_addr = 16'h0021; bus.if_req = 1'b1;
    push(OWN_IF, 1'b0, 16'h0021, 16'h0, -1);
    wait_done(OWN_IF, "t5_pre_timeout");
    bus.if_req = 1'b0;
    @(negedge clk);
    t = cyc;
    bus.mem_addr = 16'h0008; bus.mem_rd = 1'b1;
    push(OWN_MEM, 1'b0, 16'h0008, 16'h0, t + 1);
    repeat (2) @(negedge clk);
    bus.mem_rd = 1'b0;
    chk("t5_ifrd_before", bus.if_rdata, 16'hA021);
    do_reset("t5_rst");
    e0 = n_en;
    d0 = n_done;
    repeat (6) @(negedge clk);
    chk("t5_no_en", n_en, e0);
    chk("t5_no_done", n_done, d0);
    t = cyc;
    bus.mem_addr = 16'h0010; bus.mem_rd = 1'b1;
    push(OWN_MEM, 1'b0, 16'h0010, 16'h0, t + 1);
    wait_done(OWN_MEM, "t5_timeout");
    chk("t5_cyc", cyc, t + 3);
    chk("t5_rdata", bus.mem_rdata, 16'h1234);
    bus.mem_rd = 1'b0;

    // 6: read and write together -> sticky err, performed as write
    repeat (2) @(negedge clk);
    chk("t6_err_pre", bus.err, 0);
    t = cyc;
    bus.mem_addr = 16'h0030; bus.mem_wdata = 16'h55AA;
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1;
    push(OWN_MEM, 1'b1, 16'h0030, 16'h55AA, t + 1);
    @(negedge clk);
    chk("t6_err_set", bus.err, 1);
    wait_done(OWN_MEM, "t6_timeout");
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", bus.err, 1);
    t = cyc;
    bus.if_addr = 16'h0030; bus.if_req = 1'b1;
    push(OWN_IF, 1'b0, 16'h0030, 16'h0, t + 1);
    wait_done(OWN_IF, "t6_rb_timeout");
    chk("t6_readback", bus.if_rdata, 16'h55AA);
    bus.if_req = 1'b0;
    chk("t6_err_still", bus.err, 1);
    @(negedge clk);
    do_reset("t6_rst");
    @(negedge clk);
    chk("t6_err_clear", bus.err, 0);
    chk("sb_empty", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
